// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq
//   Avalon-MM bidirectional GPIO slave with configurable width, an input
//   synchroniser, atomic set/clear of output bits, per-bit edge capture and
//   a level interrupt towards the CPU.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data; only [WIDTH-1:0] is used
//   readdata    registered read data, zero-extended to 32 bits
//   irq         level interrupt, active high, registered
//   bidir_port  pin bus; each pin is driven only when its DIR bit is 1
//
// Register map (word addresses):
//   0 DATA     read: synchronised pin state; write: load data_out
//   1 DIR      read/write, 1 = pin is an output
//   2 IRQMASK  read/write
//   3 EDGECAP  read: captured edges; write 1 clears a bit
//   4 OUTSET   write: data_out |= wd (reads 0)
//   5 OUTCLR   write: data_out &= ~wd (reads 0)
//   6,7        read 0, writes ignored
module gpio_edge_irq #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // State
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] data_dir_q, data_dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    // Decoded bus and datapath helpers
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rd_sel;

    assign wr_en   = chipselect & ~write_n;
    assign wd      = writedata[WIDTH-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];

    // Pin drivers: tri-state per bit under control of DIR.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        assign bidir_port[gi] = data_dir_q[gi] ? data_out_q[gi] : 1'bz;
    end

    // Synchroniser chain; the first stage samples the pins even when they
    // are being driven by this block, so DATA always reflects the pad.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = bidir_port;
        end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    // Edge detector works on the synchronised value and its one-clock
    // delayed copy, in parallel with the DATA read path.
    if (EDGE_TYPE == 0) begin : g_rise
        assign edge_det = sync_in & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_det = ~sync_in & prev_q;
    end else begin : g_any
        assign edge_det = sync_in ^ prev_q;
    end

    always_comb begin
        data_out_d = data_out_q;
        data_dir_d = data_dir_q;
        irq_mask_d = irq_mask_q;
        edge_clr   = '0;
        prev_d     = sync_in;

        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     data_dir_d = wd;
                ADDR_IRQMASK: irq_mask_d = wd;
                ADDR_EDGECAP: edge_clr   = wd;
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:      ;
            endcase
        end

        // A newly detected edge wins over a same-cycle write-1-clear.
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_det;

        // Read mux runs every clock regardless of chipselect.
        case (address)
            ADDR_DATA:    rd_sel = sync_in;
            ADDR_DIR:     rd_sel = data_dir_q;
            ADDR_IRQMASK: rd_sel = irq_mask_q;
            ADDR_EDGECAP: rd_sel = edge_cap_q;
            default:      rd_sel = '0;
        endcase
        readdata_d              = '0;
        readdata_d[WIDTH-1:0]   = rd_sel;

        irq_d = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT;
            data_dir_q <= RESET_DIR;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            data_dir_q <= data_dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q     <= prev_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq
//   Two instances: u_rise (32 pins, 2 sync stages, rising-edge capture) and
//   u_any (16 pins, 3 sync stages, any-edge capture, RESET_OUT=0xA5A5).
//   Bus inputs are shared except chipselect. Expected read results are
//   queued when a bus cycle is driven and compared after the clock edge
//   that registers readdata/irq.
module tb_gpio_edge_irq;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs0, cs1;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
    wire  [31:0] pins0;
    wire  [15:0] pins1;
    logic [31:0] drv0, en0;
    logic [15:0] drv1, en1;

    int total;
    int bad;
    int cyc;

    typedef struct {
        int          dev;
        logic [31:0] rd;
        logic        irq;
        int          due;
        string       tag;
    } exp_t;
    exp_t sb[$];

    gpio_edge_irq #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0),
        .RESET_DIR(32'h0), .RESET_OUT(32'h0)
    ) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs0), .write_n(write_n), .writedata(writedata),
        .readdata(rd0), .irq(irq0), .bidir_port(pins0)
    );

    gpio_edge_irq #(
        .WIDTH(16), .SYNC_STAGES(3), .EDGE_TYPE(2),
        .RESET_DIR(16'h0), .RESET_OUT(16'hA5A5)
    ) u_any (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs1), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .irq(irq1), .bidir_port(pins1)
    );

    // External pin drivers
    for (genvar gi = 0; gi < 32; gi++) begin : g_drv0
        assign pins0[gi] = en0[gi] ? drv0[gi] : 1'bz;
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_drv1
        assign pins1[gi] = en1[gi] ? drv1[gi] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare every entry due at this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.dev == 0) begin
                    check_val({e.tag, "_rd"}, rd0, e.rd);
                    check_val({e.tag, "_irq"}, 32'(irq0), 32'(e.irq));
                end else begin
                    check_val({e.tag, "_rd"}, rd1, e.rd);
                    check_val({e.tag, "_irq"}, 32'(irq1), 32'(e.irq));
                end
            end
        end
    end

    task automatic push(input int dev, input logic [31:0] er, input logic ei, input string tag);
        exp_t e;
        e.dev = dev;
        e.rd  = er;
        e.irq = ei;
        e.due = cyc + 1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic rd(input int dev, input logic [2:0] a, input logic [31:0] er,
                      input logic ei, input string tag);
        cs0 = 1'b0;
        cs1 = 1'b0;
        write_n = 1'b1;
        address = a;
        push(dev, er, ei, tag);
        @(negedge clk);
    endtask

    task automatic wr(input int dev, input logic [2:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] er, input logic ei, input string tag);
        cs0 = (dev == 0);
        cs1 = (dev == 1);
        write_n = 1'b0;
        address = a;
        writedata = d;
        if (chk) push(dev, er, ei, tag);
        @(posedge clk);
        #1;
        cs0 = 1'b0;
        cs1 = 1'b0;
        write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cs0 = 1'b0;
        cs1 = 1'b0;
        write_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        cs0 = 1'b0;
        cs1 = 1'b0;
        write_n = 1'b1;
        address = 3'd0;
        writedata = 32'h0;
        en0 = '1;
        drv0 = '0;
        en1 = '1;
        drv1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_rd0", rd0, 32'h0);
        check_val("rst_irq0", 32'(irq0), 32'h0);
        check_val("rst_rd1", rd1, 32'h0);
        check_val("rst_irq1", 32'(irq1), 32'h0);
        reset_n = 1'b1;
        idle(1);
        for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'h0, 1'b0, $sformatf("map0_a%0d", a));
        for (int a = 0; a < 8; a++) rd(1, 3'(a), 32'h0, 1'b0, $sformatf("map1_a%0d", a));

        // Output path on u_rise
        en0  = 32'hFFFF_0000;
        drv0 = 32'hABCC_0000;
        wr(0, 3'd1, 32'h0000_FFFF, 1'b1, 32'h0, 1'b0, "wr_dir");
        wr(0, 3'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, "");
        check_val("pins_lo", 32'(pins0[15:0]), 32'h5678);
        wr(0, 3'd4, 32'h0001_0001, 1'b0, 32'h0, 1'b0, "");
        wr(0, 3'd5, 32'h0000_0008, 1'b0, 32'h0, 1'b0, "");
        check_val("pins_setclr", 32'(pins0[15:0]), 32'h5671);
        idle(3);
        rd(0, 3'd0, 32'hABCC_5671, 1'b0, "data_in");
        rd(0, 3'd4, 32'h0, 1'b0, "outset_rd");
        rd(0, 3'd5, 32'h0, 1'b0, "outclr_rd");
        wr(0, 3'd6, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "");
        rd(0, 3'd1, 32'h0000_FFFF, 1'b0, "dir_keep");
        en0 = 32'hFFFE_0000;
        wr(0, 3'd1, 32'h0001_FFFF, 1'b0, 32'h0, 1'b0, "");
        check_val("pin16", 32'(pins0[16]), 32'h1);

        // Back to all inputs, clear captured edges
        wr(0, 3'd1, 32'h0, 1'b0, 32'h0, 1'b0, "");
        en0  = '1;
        drv0 = '0;
        idle(5);
        wr(0, 3'd3, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "");
        rd(0, 3'd3, 32'h0, 1'b0, "cap_cleared");

        // Rising edge on pin2, mask bit2
        wr(0, 3'd2, 32'h4, 1'b0, 32'h0, 1'b0, "");
        rd(0, 3'd2, 32'h4, 1'b0, "mask_rd");
        drv0[2] = 1'b1;
        rd(0, 3'd3, 32'h0, 1'b0, "rise_p1");
        rd(0, 3'd3, 32'h0, 1'b0, "rise_p2");
        rd(0, 3'd0, 32'h4, 1'b0, "rise_data_lat");
        rd(0, 3'd3, 32'h4, 1'b1, "rise_cap_irq");
        wr(0, 3'd3, 32'h4, 1'b1, 32'h4, 1'b1, "clr_cycle");
        rd(0, 3'd3, 32'h0, 1'b0, "clr_irq_low");

        // Falling edge is ignored by a rising-edge instance
        drv0[2] = 1'b0;
        idle(4);
        rd(0, 3'd3, 32'h0, 1'b0, "fall_ignored");

        // Edge set and write-1-clear on the same clock: set wins
        drv0[2] = 1'b1;
        rd(0, 3'd3, 32'h0, 1'b0, "sim_p1");
        rd(0, 3'd3, 32'h0, 1'b0, "sim_p2");
        wr(0, 3'd3, 32'h4, 1'b1, 32'h0, 1'b0, "sim_wr");
        rd(0, 3'd3, 32'h4, 1'b1, "sim_set_wins");
        rd(0, 3'd3, 32'h4, 1'b1, "sim_hold");

        // Asynchronous reset mid-capture
        check_val("pre_rst_irq", 32'(irq0), 32'h1);
        reset_n = 1'b0;
        drv0[2] = 1'b0;
        #1;
        check_val("arst_irq", 32'(irq0), 32'h0);
        check_val("arst_rd", rd0, 32'h0);
        idle(2);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) rd(0, 3'd3, 32'h0, 1'b0, $sformatf("post_rst_cap%0d", i));
        rd(0, 3'd2, 32'h0, 1'b0, "post_rst_mask");
        drv0[2] = 1'b1;
        idle(4);
        rd(0, 3'd3, 32'h4, 1'b0, "cap_unmasked");

        // u_any: falling edge on pin5 with mask 0, then unmask
        drv1[5] = 1'b1;
        idle(6);
        wr(1, 3'd3, 32'h0000_FFFF, 1'b0, 32'h0, 1'b0, "");
        rd(1, 3'd3, 32'h0, 1'b0, "any_clr");
        rd(1, 3'd0, 32'h20, 1'b0, "any_data");
        drv1[5] = 1'b0;
        rd(1, 3'd3, 32'h0, 1'b0, "any_p1");
        rd(1, 3'd3, 32'h0, 1'b0, "any_p2");
        rd(1, 3'd0, 32'h20, 1'b0, "any_data_old");
        rd(1, 3'd0, 32'h0, 1'b0, "any_data_new");
        rd(1, 3'd3, 32'h20, 1'b0, "any_fall_cap");
        wr(1, 3'd2, 32'h20, 1'b1, 32'h0, 1'b0, "any_mask_wr");
        rd(1, 3'd3, 32'h20, 1'b1, "any_irq");

        // u_any: width handling and reset output value
        en1 = '0;
        wr(1, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, "any_dir_wr");
        rd(1, 3'd1, 32'h0000_FFFF, 1'b1, "any_dir_width");
        check_val("any_pins_rst_out", 32'(pins1), 32'h0000_A5A5);
        idle(4);
        rd(1, 3'd0, 32'h0000_A5A5, 1'b1, "any_data_loop");
        wr(1, 3'd5, 32'hFFFF_00FF, 1'b0, 32'h0, 1'b0, "");
        check_val("any_outclr", 32'(pins1), 32'h0000_A500);
        wr(1, 3'd4, 32'h000F_0000, 1'b0, 32'h0, 1'b0, "");
        check_val("any_outset_upper", 32'(pins1), 32'h0000_A500);

        idle(2);
        check_val("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
